// File: rtl/avalon_mem_responder.sv
// Avalon-MM word-memory responder with programmable waitrequest throttling
// and read/write/error counters.
module avalon_mem_responder #(
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic        avs_waitrequest,
  output logic [15:0] rd_cnt,
  output logic [15:0] wr_cnt,
  output logic [7:0]  err_cnt
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        is_wr_q, is_wr_d;
  logic        coll_q, coll_d;
  logic [29:0] idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q;
  logic [15:0] rd_q, wr_q;
  logic [7:0]  err_q;
  logic        go_ack;

  logic [31:0] mem [DEPTH];

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^avs_address[1:0];

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    is_wr_d = is_wr_q;
    coll_d  = coll_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    go_ack  = 1'b0;
    case (state_q)
      IDLE: begin
        if (avs_read || avs_write) begin
          is_wr_d = avs_write;
          coll_d  = avs_read & avs_write;
          idx_d   = avs_address[31:2];
          wdata_d = avs_writedata;
          wcnt_d  = 4'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Initiator dropped its request: abandon the access without committing.
        if (!avs_read && !avs_write) begin
          state_d = IDLE;
        end else if (wcnt_q == 4'd1) begin
          state_d = ACK;
          go_ack  = 1'b1;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With zero wait cycles the commit happens straight out of IDLE, so the
  // operands come from the bus rather than the latch.
  logic        c_wr, c_coll, c_inrange, c_err;
  logic [29:0] c_idx;
  logic [31:0] c_data;
  always_comb begin
    c_wr      = (state_q == IDLE) ? avs_write : is_wr_q;
    c_coll    = (state_q == IDLE) ? (avs_read & avs_write) : coll_q;
    c_idx     = (state_q == IDLE) ? avs_address[31:2] : idx_q;
    c_data    = (state_q == IDLE) ? avs_writedata : wdata_q;
    c_inrange = (c_idx < 30'(DEPTH));
    c_err     = c_coll | ~c_inrange;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      is_wr_q <= 1'b0;
      coll_q  <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      is_wr_q <= is_wr_d;
      coll_q  <= coll_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      if (go_ack) begin
        if (c_wr) begin
          wr_q <= wr_q + 16'd1;
        end else begin
          rd_q    <= rd_q + 16'd1;
          rdata_q <= c_inrange ? mem[c_idx[AW-1:0]] : ERR_DATA;
        end
        if (c_err && err_q != 8'hFF) err_q <= err_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && go_ack && c_wr && c_inrange) mem[c_idx[AW-1:0]] <= c_data;
  end

  assign avs_waitrequest = (state_q != ACK);
  assign avs_readdata    = rdata_q;
  assign rd_cnt          = rd_q;
  assign wr_cnt          = wr_q;
  assign err_cnt         = err_q;
endmodule
